// File: rtl/n64adv_vinfo_pkg.sv
// n64adv_vinfo_pkg: shared sync-bit indices, vinfo bit positions and defaults for video-mode detection
package n64adv_vinfo_pkg;
  localparam int NVSYNC_BIT = 3;
  localparam int NHSYNC_BIT = 1;
  localparam int PAL_THRESH_DEF = 288;
  localparam int LINE_CNT_W_DEF = 10;
  localparam int PALMODE_BIT = 1;
  localparam int N64_480I_BIT = 0;
  typedef enum logic {ST_SEED, ST_TRACK} stab_state_e;
endpackage

// File: rtl/n64_vinfo_stabilizer.sv
// n64_vinfo_stabilizer: hysteresis filter committing a mode after STABLE_FIELDS identical candidates
module n64_vinfo_stabilizer
  import n64adv_vinfo_pkg::*;
#(
  parameter int STABLE_FIELDS = 2
) (
  input  logic       VCLK,
  input  logic       VRST,
  input  logic       cand_valid,
  input  logic [1:0] cand,
  input  logic       timeout,
  output logic [1:0] vinfo_o,
  output logic       vinfo_valid
);
  localparam int MW = $clog2(STABLE_FIELDS + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FIELDS);
  stab_state_e state, state_nx;
  logic [1:0] last_cand, last_nx, vinfo_nx;
  logic [MW-1:0] match_cnt, match_nx;
  logic track_upd, commit, valid_nx;
  always_ff @(posedge VCLK or posedge VRST)
    if (VRST) begin
      state <= ST_SEED;
      last_cand <= '0;
      match_cnt <= '0;
      vinfo_o <= '0;
      vinfo_valid <= 1'b0;
    end else begin
      state <= state_nx;
      last_cand <= last_nx;
      match_cnt <= match_nx;
      vinfo_o <= vinfo_nx;
      vinfo_valid <= valid_nx;
    end
  always_comb state_nx = timeout ? ST_SEED : cand_valid ? ST_TRACK : state;
  // the seeding field only arms TRACK; its candidate is meaningless
  always_comb begin
    track_upd = cand_valid & !timeout & (state == ST_TRACK);
    last_nx = track_upd ? cand : last_cand;
    match_nx = timeout ? '0 :
               !track_upd ? match_cnt :
               cand != last_cand ? MW'(1) :
               match_cnt == MATCH_MAX ? match_cnt : match_cnt + MW'(1);
    commit = track_upd & (match_nx == MATCH_MAX);
    vinfo_nx = commit ? last_nx : vinfo_o;
    valid_nx = !timeout & (vinfo_valid | commit);
  end
endmodule

// File: rtl/n64_vinfo_detect.sv
// n64_vinfo_detect: classifies the N64 video stream into {palmode, n64_480i} from VS/HS edges
module n64_vinfo_detect
  import n64adv_vinfo_pkg::*;
#(
  parameter int LINE_CNT_W = LINE_CNT_W_DEF,
  parameter int PAL_THRESH = PAL_THRESH_DEF,
  parameter int STABLE_FIELDS = 2
) (
  input  logic                  VCLK,
  input  logic                  VRST,
  input  logic                  nVDSYNC,
  input  logic [3:0]            Sync_pre,
  input  logic [3:0]            Sync_cur,
  output logic [1:0]            vinfo_o,
  output logic                  vinfo_valid,
  output logic                  field_o,
  output logic [LINE_CNT_W-1:0] lines_o
);
  localparam logic [LINE_CNT_W-1:0] PAL_TH = LINE_CNT_W'(PAL_THRESH);
  logic strobe, hs_edge, vs_edge, timeout, field_prev, cand_valid;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [1:0] cand;
  always_comb begin
    strobe = !nVDSYNC;
    hs_edge = strobe & Sync_pre[NHSYNC_BIT] & !Sync_cur[NHSYNC_BIT];
    vs_edge = strobe & Sync_pre[NVSYNC_BIT] & !Sync_cur[NVSYNC_BIT];
    timeout = hs_edge & !vs_edge & (&line_cnt);
    cand[PALMODE_BIT] = lines_o >= PAL_TH;
    cand[N64_480I_BIT] = field_o != field_prev;
  end
  // candidate is evaluated one cycle after the field closes, from the registered field stats
  always_ff @(posedge VCLK or posedge VRST)
    if (VRST) begin
      line_cnt <= '0;
      lines_o <= '0;
      field_o <= 1'b0;
      field_prev <= 1'b0;
      cand_valid <= 1'b0;
    end else begin
      cand_valid <= vs_edge;
      if (vs_edge) begin
        line_cnt <= LINE_CNT_W'(hs_edge);
        lines_o <= line_cnt;
        field_prev <= field_o;
        field_o <= Sync_cur[NHSYNC_BIT];
      end else if (hs_edge && !(&line_cnt)) begin
        line_cnt <= line_cnt + LINE_CNT_W'(1);
      end
    end
  n64_vinfo_stabilizer #(.STABLE_FIELDS(STABLE_FIELDS)) u_stab (
    .VCLK       (VCLK),
    .VRST       (VRST),
    .cand_valid (cand_valid),
    .cand       (cand),
    .timeout    (timeout),
    .vinfo_o    (vinfo_o),
    .vinfo_valid(vinfo_valid)
  );
endmodule
